// File: rtl/lc3_mem_ctrl_if.sv
// Bus between the LC-3 datapath/control FSM and lc3_mem_ctrl, including the
// keyboard and display device lines. The master drives requests; the slave is the controller.
interface lc3_mem_ctrl_if;
  logic        mem_en;
  logic        r_w;
  logic [15:0] mar;
  logic [15:0] mdr_in;
  logic [15:0] mdr_out;
  logic        ready;
  logic [7:0]  kbd_data;
  logic        kbd_valid;
  logic [7:0]  ddr_data;
  logic        ddr_valid;
  logic        ddr_ready;

  modport master (
    output mem_en, r_w, mar, mdr_in, kbd_data, kbd_valid, ddr_ready,
    input  mdr_out, ready, ddr_data, ddr_valid
  );

  modport slave (
    input  mem_en, r_w, mar, mdr_in, kbd_data, kbd_valid, ddr_ready,
    output mdr_out, ready, ddr_data, ddr_valid
  );
endinterface

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory controller: block-RAM access with RD_LAT-cycle read latency and a one-cycle
// ready pulse per access. Define LC3_MMIO_EN to decode the xFE00-xFFFF keyboard/display page.
module lc3_mem_ctrl #(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  lc3_mem_ctrl_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {IDLE, RD_WAIT, WR, IO, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] mdr_q, mdr_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        wr_q, wr_d;

  logic [15:0] ram [DEPTH];
  logic [15:0] rd_pipe_q [RD_LAT];

  logic        dev_sel;
  logic        ram_we;
  logic        io_commit;
  logic [15:0] io_rdata;

  // WR and IO share a two-cycle shape: commit on the first edge, leave on the second.
  assign ram_we    = (state_q == WR) && (cnt_q == 3'd0);
  assign io_commit = (state_q == IO) && (cnt_q == 3'd0);

  assign bus.ready   = (state_q == DONE);
  assign bus.mdr_out = mdr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mdr_d   = mdr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    case (state_q)
      IDLE: begin
        if (bus.mem_en) begin
          addr_d  = bus.mar;
          wdata_d = bus.mdr_in;
          wr_d    = bus.r_w;
          cnt_d   = 3'd0;
          if (dev_sel)        state_d = IO;
          else if (bus.r_w)   state_d = WR;
          else                state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        // The last pipeline stage holds the RAM word once RD_LAT edges have elapsed.
        if (cnt_q == 3'(RD_LAT)) begin
          mdr_d   = rd_pipe_q[RD_LAT-1];
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      WR: begin
        if (cnt_q == 3'd0) cnt_d   = 3'd1;
        else               state_d = DONE;
      end
      IO: begin
        if (cnt_q == 3'd0) begin
          if (!wr_q) mdr_d = io_rdata;
          cnt_d = 3'd1;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      mdr_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mdr_q   <= mdr_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    wr_q    <= wr_d;
  end

  // RAM has no reset so its contents survive rst.
  always_ff @(posedge clk) begin
    if (ram_we) ram[addr_q[ADDR_W-1:0]] <= wdata_q;
    rd_pipe_q[0] <= ram[addr_q[ADDR_W-1:0]];
    for (int i = 1; i < RD_LAT; i++) rd_pipe_q[i] <= rd_pipe_q[i-1];
  end

`ifdef LC3_MMIO_EN
  logic       kbd_full_q, kbd_full_d;
  logic [7:0] kbd_byte_q, kbd_byte_d;
  logic       ddr_valid_q, ddr_valid_d;
  logic [7:0] ddr_data_q, ddr_data_d;

  assign dev_sel       = (bus.mar[15:9] == 7'h7F);
  assign bus.ddr_valid = ddr_valid_q;
  assign bus.ddr_data  = ddr_data_q;

  always_comb begin
    case (addr_q)
      16'hFE00: io_rdata = {kbd_full_q, 15'b0};
      16'hFE02: io_rdata = {8'b0, kbd_byte_q};
      16'hFE04: io_rdata = {~ddr_valid_q, 15'b0};
      default:  io_rdata = 16'h0000;
    endcase
  end

  always_comb begin
    kbd_full_d  = kbd_full_q;
    kbd_byte_d  = kbd_byte_q;
    ddr_valid_d = ddr_valid_q;
    ddr_data_d  = ddr_data_q;
    if (io_commit && !wr_q && (addr_q == 16'hFE02)) kbd_full_d = 1'b0;
    // A new keystroke wins over a same-edge KBDR read clearing the flag.
    if (bus.kbd_valid) begin
      kbd_byte_d = bus.kbd_data;
      kbd_full_d = 1'b1;
    end
    if (io_commit && wr_q && (addr_q == 16'hFE06) && !ddr_valid_q) begin
      ddr_data_d  = wdata_q[7:0];
      ddr_valid_d = 1'b1;
    end else if (ddr_valid_q && bus.ddr_ready) begin
      ddr_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kbd_full_q  <= 1'b0;
      kbd_byte_q  <= 8'h00;
      ddr_valid_q <= 1'b0;
      ddr_data_q  <= 8'h00;
    end else begin
      kbd_full_q  <= kbd_full_d;
      kbd_byte_q  <= kbd_byte_d;
      ddr_valid_q <= ddr_valid_d;
      ddr_data_q  <= ddr_data_d;
    end
  end
`else
  logic unused_ok;

  assign dev_sel       = 1'b0;
  assign io_rdata      = 16'h0000;
  assign bus.ddr_valid = 1'b0;
  assign bus.ddr_data  = 8'h00;
  assign unused_ok     = ^{bus.kbd_data, bus.kbd_valid, bus.ddr_ready, addr_q, wr_q, io_commit};
`endif

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Scoreboard bench for lc3_mem_ctrl: two instances (RD_LAT=1 and RD_LAT=3) share one stimulus
// stream; a behavioural model predicts each response, a monitor checks it when ready pulses.
`timescale 1ns/1ps
module tb_lc3_mem_ctrl;
  localparam int ADDR_W = 10;
  localparam int WORDS  = 1 << ADDR_W;
  localparam int LAT_A  = 1;
  localparam int LAT_B  = 3;

  typedef struct packed {
    logic [15:0] data;
    logic        dv;
    logic [7:0]  dd;
    logic [31:0] lat;
    logic [31:0] acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  exp_t q0[$];
  exp_t q1[$];

  logic [15:0] mem_m [int];
  int          wlist[$];
  logic [15:0] m_mdr;
  logic        m_kfull;
  logic [7:0]  m_kbyte;
  logic        m_dvalid;
  logic [7:0]  m_ddata;

  lc3_mem_ctrl_if bus_a();
  lc3_mem_ctrl_if bus_b();

  assign bus_b.mem_en    = bus_a.mem_en;
  assign bus_b.r_w       = bus_a.r_w;
  assign bus_b.mar       = bus_a.mar;
  assign bus_b.mdr_in    = bus_a.mdr_in;
  assign bus_b.kbd_data  = bus_a.kbd_data;
  assign bus_b.kbd_valid = bus_a.kbd_valid;
  assign bus_b.ddr_ready = bus_a.ddr_ready;

  lc3_mem_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(LAT_A)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  lc3_mem_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(LAT_B)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic mon(input int k, input logic [15:0] mo, input logic dv, input logic [7:0] dd);
    exp_t e;
    if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
      chk_cnt++;
      $display("FAIL dut%0d_unexpected_ready: got ready=1 at cycle %0d, required no pulse", k, cyc);
      return;
    end
    if (k == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    check($sformatf("dut%0d_mdr_out", k), {16'h0, mo}, {16'h0, e.data});
    check($sformatf("dut%0d_latency", k), cyc - e.acc, e.lat);
    check($sformatf("dut%0d_ddr_valid", k), {31'h0, dv}, {31'h0, e.dv});
    check($sformatf("dut%0d_ddr_data", k), {24'h0, dd}, {24'h0, e.dd});
  endtask

  always @(negedge clk) begin
    if (bus_a.ready) mon(0, bus_a.mdr_out, bus_a.ddr_valid, bus_a.ddr_data);
    if (bus_b.ready) mon(1, bus_b.mdr_out, bus_b.ddr_valid, bus_b.ddr_data);
  end

  task automatic model_reset();
    m_mdr = 16'h0; m_kfull = 1'b0; m_kbyte = 8'h0; m_dvalid = 1'b0; m_ddata = 8'h0;
  endtask

  // Reference behaviour of one access; sets ram_rd when the response latency follows RD_LAT.
  task automatic model_access(input logic wr, input logic [15:0] a, input logic [15:0] d,
                              input logic kv, input logic [7:0] kd, output logic ram_rd);
    logic dev;
    int   idx;
    dev = 1'b0;
`ifdef LC3_MMIO_EN
    dev = (a[15:9] == 7'h7F);
`endif
    ram_rd = 1'b0;
    if (dev) begin
      if (!wr) begin
        if (a == 16'hFE00)      m_mdr = {m_kfull, 15'b0};
        else if (a == 16'hFE02) begin m_mdr = {8'b0, m_kbyte}; m_kfull = 1'b0; end
        else if (a == 16'hFE04) m_mdr = {~m_dvalid, 15'b0};
        else                    m_mdr = 16'h0;
      end else if (a == 16'hFE06 && !m_dvalid) begin
        m_ddata = d[7:0]; m_dvalid = 1'b1;
      end
    end else begin
      idx = int'(a) % WORDS;
      if (wr) begin mem_m[idx] = d; wlist.push_back(idx); end
      else begin m_mdr = mem_m[idx]; ram_rd = 1'b1; end
    end
    if (kv) begin m_kbyte = kd; m_kfull = 1'b1; end
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      chk_cnt++;
      $display("FAIL drain_timeout: got %0d/%0d responses pending, required 0", q0.size(), q1.size());
      q0.delete(); q1.delete();
    end
  endtask

  task automatic access(input logic wr, input logic [15:0] a, input logic [15:0] d,
                        input logic kv, input logic [7:0] kd);
    int   acc;
    logic ram_rd;
    exp_t e;
    @(negedge clk);
    bus_a.mem_en = 1'b1; bus_a.r_w = wr; bus_a.mar = a; bus_a.mdr_in = d;
    @(posedge clk); #1;
    acc = cyc;
    bus_a.mem_en = 1'b0;
    bus_a.r_w    = 1'($urandom);
    bus_a.mar    = 16'($urandom);
    bus_a.mdr_in = 16'($urandom);
    if (kv) begin bus_a.kbd_valid = 1'b1; bus_a.kbd_data = kd; end
    model_access(wr, a, d, kv, kd, ram_rd);
    e.data = m_mdr; e.dv = m_dvalid; e.dd = m_ddata; e.acc = acc;
    e.lat = ram_rd ? (LAT_A + 1) : 2;
    q0.push_back(e);
    e.lat = ram_rd ? (LAT_B + 1) : 2;
    q1.push_back(e);
    if (kv) begin @(posedge clk); #1; bus_a.kbd_valid = 1'b0; end
    drain();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready_a"}, {31'h0, bus_a.ready}, 32'h0);
    check({tag, "_mdr_a"}, {16'h0, bus_a.mdr_out}, {16'h0, m_mdr});
    check({tag, "_ddr_valid_a"}, {31'h0, bus_a.ddr_valid}, {31'h0, m_dvalid});
    check({tag, "_ready_b"}, {31'h0, bus_b.ready}, 32'h0);
    check({tag, "_mdr_b"}, {16'h0, bus_b.mdr_out}, {16'h0, m_mdr});
    check({tag, "_ddr_valid_b"}, {31'h0, bus_b.ddr_valid}, {31'h0, m_dvalid});
  endtask

`ifdef LC3_MMIO_EN
  task automatic kbd_pulse(input logic [7:0] b);
    @(negedge clk);
    bus_a.kbd_valid = 1'b1; bus_a.kbd_data = b;
    @(negedge clk);
    bus_a.kbd_valid = 1'b0;
    m_kbyte = b; m_kfull = 1'b1;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] a;
    int          idx;
    bus_a.mem_en = 1'b0; bus_a.r_w = 1'b0; bus_a.mar = 16'h0; bus_a.mdr_in = 16'h0;
    bus_a.kbd_data = 8'h0; bus_a.kbd_valid = 1'b0; bus_a.ddr_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    #2 rst = 1'b1;

    access(1'b1, 16'h0010, 16'h1234, 1'b0, 8'h0);
    access(1'b0, 16'h0010, 16'h0000, 1'b0, 8'h0);
    access(1'b1, 16'h0405, 16'hBEEF, 1'b0, 8'h0);
    access(1'b0, 16'h0005, 16'h0000, 1'b0, 8'h0);

    for (int i = 0; i < 40; i++) begin
      if (wlist.size() == 0 || $urandom_range(0, 1) == 0) begin
        a = 16'($urandom);
`ifdef LC3_MMIO_EN
        if (a[15:9] == 7'h7F) a[15] = 1'b0;
`endif
        access(1'b1, a, 16'($urandom), 1'b0, 8'h0);
      end else begin
        idx = wlist[$urandom_range(0, wlist.size() - 1)];
        a = 16'(idx + WORDS * int'($urandom_range(0, 62)));
        access(1'b0, a, 16'($urandom), 1'b0, 8'h0);
      end
    end

    // Abort a read mid-flight; neither instance may pulse ready for it.
    @(negedge clk);
    bus_a.mem_en = 1'b1; bus_a.r_w = 1'b0; bus_a.mar = 16'h0010;
    @(posedge clk); #1;
    bus_a.mem_en = 1'b0;
    @(negedge clk); #2;
    rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("abort");
    access(1'b0, 16'h0010, 16'h0000, 1'b0, 8'h0);

`ifdef LC3_MMIO_EN
    kbd_pulse(8'h41);
    access(1'b0, 16'hFE00, 16'h0, 1'b0, 8'h0);
    access(1'b0, 16'hFE02, 16'h0, 1'b0, 8'h0);
    access(1'b0, 16'hFE00, 16'h0, 1'b0, 8'h0);
    kbd_pulse(8'h41);
    access(1'b0, 16'hFE02, 16'h0, 1'b1, 8'h42);
    access(1'b0, 16'hFE00, 16'h0, 1'b0, 8'h0);
    access(1'b0, 16'hFE02, 16'h0, 1'b0, 8'h0);
    access(1'b1, 16'hFE00, 16'hFFFF, 1'b0, 8'h0);
    access(1'b0, 16'hFE10, 16'h0, 1'b0, 8'h0);

    access(1'b1, 16'hFE06, 16'h0058, 1'b0, 8'h0);
    access(1'b0, 16'hFE04, 16'h0, 1'b0, 8'h0);
    access(1'b1, 16'hFE06, 16'h0059, 1'b0, 8'h0);
    @(negedge clk);
    bus_a.ddr_ready = 1'b1;
    repeat (2) @(negedge clk);
    bus_a.ddr_ready = 1'b0;
    m_dvalid = 1'b0;
    check("ddr_valid_after_ack_a", {31'h0, bus_a.ddr_valid}, {31'h0, m_dvalid});
    check("ddr_valid_after_ack_b", {31'h0, bus_b.ddr_valid}, {31'h0, m_dvalid});
    access(1'b0, 16'hFE04, 16'h0, 1'b0, 8'h0);
`else
    access(1'b1, 16'hFE06, 16'h00AA, 1'b0, 8'h0);
    access(1'b0, 16'hFE06, 16'h0, 1'b0, 8'h0);
    access(1'b0, 16'h0206, 16'h0, 1'b0, 8'h0);
    check("ddr_valid_const_a", {31'h0, bus_a.ddr_valid}, 32'h0);
    check("ddr_valid_const_b", {31'h0, bus_b.ddr_valid}, 32'h0);
`endif

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
